// File: rtl/signed_count_ctrl.sv
// Signed up/down event counter with a sign/magnitude conversion stage.
// Each accepted event runs IDLE -> UPD (count update) -> CONV (sign/magnitude) -> IDLE.
module signed_count_ctrl #(
    parameter int WIDTH  = 8,
    parameter bit SAT_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enter,
    input  logic             exit,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic             sign,
    output logic [WIDTH-1:0] magnitude,
    output logic             mag_valid,
    output logic             busy,
    output logic             ovf,
    output logic             dropped,
    output logic [1:0]       dbg_state
);

    // Handshake: enter/exit are single-cycle requests with no ready; requests
    // arriving while busy are parked in one pending slot per direction, and a
    // second request into an occupied slot is lost and flagged via dropped.
    // mag_valid is a one-cycle pulse qualifying sign/magnitude.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UPD  = 2'd1,
        CONV = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] DEC_OP  = ~ONE + ONE;
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state, state_n;
    logic [WIDTH-1:0] count_n, mag_n;
    logic             sign_n, mag_valid_n, ovf_n, dropped_n;
    logic             pend_in, pend_in_n, pend_out, pend_out_n;
    logic             dir_up, dir_up_n;
    logic             inc, dec;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= '0;
            sign      <= 1'b0;
            magnitude <= '0;
            mag_valid <= 1'b0;
            ovf       <= 1'b0;
            dropped   <= 1'b0;
            pend_in   <= 1'b0;
            pend_out  <= 1'b0;
            dir_up    <= 1'b0;
        end else begin
            state     <= state_n;
            count     <= count_n;
            sign      <= sign_n;
            magnitude <= mag_n;
            mag_valid <= mag_valid_n;
            ovf       <= ovf_n;
            dropped   <= dropped_n;
            pend_in   <= pend_in_n;
            pend_out  <= pend_out_n;
            dir_up    <= dir_up_n;
        end
    end

    always_comb begin
        state_n     = state;
        count_n     = count;
        sign_n      = sign;
        mag_n       = magnitude;
        mag_valid_n = 1'b0;
        ovf_n       = ovf;
        dropped_n   = dropped;
        pend_in_n   = pend_in;
        pend_out_n  = pend_out;
        dir_up_n    = dir_up;
        inc         = enter | pend_in;
        dec         = exit | pend_out;

        if (clear) begin
            state_n    = IDLE;
            count_n    = '0;
            sign_n     = 1'b0;
            mag_n      = '0;
            ovf_n      = 1'b0;
            dropped_n  = 1'b0;
            pend_in_n  = 1'b0;
            pend_out_n = 1'b0;
        end else begin
            // While busy, park new requests; a second one into a full slot is lost.
            if (state != IDLE) begin
                if (enter) begin
                    if (pend_in) dropped_n = 1'b1;
                    pend_in_n = 1'b1;
                end
                if (exit) begin
                    if (pend_out) dropped_n = 1'b1;
                    pend_out_n = 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (inc && dec) begin
                        pend_in_n  = 1'b0;
                        pend_out_n = 1'b0;
                    end else if (inc) begin
                        dir_up_n  = 1'b1;
                        pend_in_n = 1'b0;
                        state_n   = UPD;
                    end else if (dec) begin
                        dir_up_n   = 1'b0;
                        pend_out_n = 1'b0;
                        state_n    = UPD;
                    end
                end
                UPD: begin
                    if (dir_up) begin
                        if (count == MAX_POS) begin
                            ovf_n   = 1'b1;
                            count_n = SAT_EN ? count : count + ONE;
                        end else begin
                            count_n = count + ONE;
                        end
                    end else begin
                        if (count == MIN_NEG) begin
                            ovf_n   = 1'b1;
                            count_n = SAT_EN ? count : count + DEC_OP;
                        end else begin
                            count_n = count + DEC_OP;
                        end
                    end
                    state_n = CONV;
                end
                CONV: begin
                    sign_n      = count[WIDTH-1];
                    mag_n       = count[WIDTH-1] ? (~count + ONE) : count;
                    mag_valid_n = 1'b1;
                    state_n     = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign busy      = (state == UPD) || (state == CONV);
    assign dbg_state = state;

endmodule
